alu_arbiter: RTL and testbench

- Shares one combinational 8-bit ALU (opA/opB/opS -> R, 3-bit op select) between two requesters.
- Each requester submits an operation over a valid/ready command channel and receives the result over a valid/ready response channel.
- The block arbitrates round-robin, registers the operands and drives the ALU. It captures R and returns the result to the winning requester.
- It sits between client logic and the ALU instance (`top`).

---
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU driven) -> RESP (hold result until accepted).
module alu_arbiter #(
   parameter int unsigned W    = 8,
   parameter int unsigned CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [2*W-1:0]  req_a,
   input  logic [2*W-1:0]  req_b,
   input  logic [5:0]      req_s,
   output logic [1:0]      rsp_valid,
   input  logic [1:0]      rsp_ready,
   output logic [W-1:0]    rsp_r,
   output logic [W-1:0]    alu_a,
   output logic [W-1:0]    alu_b,
   output logic [2:0]      alu_s,
   input  logic [W-1:0]    alu_r,
   output logic            busy,
   output logic [CNTW-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   ptr;
   logic   owner;
   logic   winner;
   logic   accept;
   logic   done;

   // A lone requester always wins; the pointer only breaks ties.
   always_comb begin
      winner = 1'b0;
      case (req_valid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ptr;
         default: winner = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // Grant is suppressed while reset is held so nothing looks accepted.
            if (rst_n && (|req_valid)) begin
               req_ready[winner] = 1'b1;
               accept            = 1'b1;
               state_nxt         = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (rsp_ready[owner]) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = (state != IDLE);

   // The ALU inputs are the operand registers themselves, so they hold outside EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         owner    <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_s    <= '0;
         rsp_r    <= '0;
         ops_done <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner <= winner;
            alu_a <= winner ? req_a[2*W-1:W] : req_a[W-1:0];
            alu_b <= winner ? req_b[2*W-1:W] : req_b[W-1:0];
            alu_s <= winner ? req_s[5:3]     : req_s[2:0];
         end
         if (state == EXEC) begin
            rsp_r <= alu_r;
         end
         if (done) begin
            ptr      <= ~owner;
            ops_done <= ops_done + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached; a second
// instance with a 2-bit counter shares all inputs to exercise counter wrap.
module tb_alu_arbiter;

   localparam int unsigned W = 8;

   typedef struct {
      int         k;
      bit         other;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] s;
      logic [7:0] r;
      int         stall;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [2*W-1:0] req_a, req_b;
   logic [5:0]    req_s;
   logic [1:0]    rsp_ready;

   logic [1:0]    req_ready, rsp_valid;
   logic [W-1:0]  rsp_r, alu_a, alu_b, alu_r;
   logic [2:0]    alu_s;
   logic          busy;
   logic [15:0]   ops_done;

   logic [1:0]    req_ready2, rsp_valid2;
   logic [W-1:0]  rsp_r2, alu_a2, alu_b2, alu_r2;
   logic [2:0]    alu_s2;
   logic          busy2;
   logic [1:0]    ops_done2;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   vec_t vecs [15];
   vec_t wrap [5];

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      case (s)
         3'd0: alu_f = a + b;
         3'd1: alu_f = a - b;
         3'd2: alu_f = a & b;
         3'd3: alu_f = a | b;
         3'd4: alu_f = a ^ b;
         3'd5: alu_f = ~a;
         3'd6: alu_f = {a[3:0], a[7:4]};
         default: alu_f = a + 8'd1;
      endcase
   endfunction

   assign alu_r  = alu_f(alu_a, alu_b, alu_s);
   assign alu_r2 = alu_f(alu_a2, alu_b2, alu_s2);

   alu_arbiter #(.W(8), .CNTW(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_s(req_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_r(alu_r),
      .busy(busy), .ops_done(ops_done)
   );

   alu_arbiter #(.W(8), .CNTW(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .req_s(req_s),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_r(rsp_r2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_r(alu_r2),
      .busy(busy2), .ops_done(ops_done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_counters();
      chk("ops_done", {16'd0, ops_done}, exp_cnt & 32'hFFFF);
      chk("ops_done_cntw2", {30'd0, ops_done2}, exp_cnt & 32'h3);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after completion.
   task automatic run_op(input vec_t v);
      logic [1:0] me;
      me = 2'b01 << v.k;
      req_a[W*v.k +: W] = v.a;
      req_b[W*v.k +: W] = v.b;
      req_s[3*v.k +: 3] = v.s;
      req_valid = v.other ? 2'b11 : me;
      rsp_ready = (v.stall != 0) ? ~me : 2'b11;
      #1;
      chk("grant", {30'd0, req_ready}, {30'd0, me});
      @(posedge clk); @(negedge clk);
      req_valid = req_valid & ~me;
      chk("exec_busy", {31'd0, busy}, 32'd1);
      chk("exec_no_ready", {30'd0, req_ready}, 32'd0);
      chk("exec_no_rsp", {30'd0, rsp_valid}, 32'd0);
      chk("alu_a", {24'd0, alu_a}, {24'd0, v.a});
      chk("alu_b", {24'd0, alu_b}, {24'd0, v.b});
      chk("alu_s", {29'd0, alu_s}, {29'd0, v.s});
      @(posedge clk); @(negedge clk);
      chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, me});
      chk("rsp_r", {24'd0, rsp_r}, {24'd0, v.r});
      for (int i = 0; i < v.stall; i++) begin
         req_valid = ~me;
         @(posedge clk); @(negedge clk);
         chk("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, me});
         chk("stall_rsp_r", {24'd0, rsp_r}, {24'd0, v.r});
         chk("stall_no_ready", {30'd0, req_ready}, 32'd0);
      end
      req_valid = v.other ? ~me : 2'b00;
      rsp_ready = me;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk("done_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("alu_a_hold", {24'd0, alu_a}, {24'd0, v.a});
      chk_counters();
      req_valid = 2'b00;
   endtask

   initial begin
      vecs[0]  = '{0, 1'b1, 8'hF0, 8'h0F, 3'd1, 8'hE1, 0};
      vecs[1]  = '{1, 1'b1, 8'h0A, 8'h05, 3'd2, 8'h00, 0};
      vecs[2]  = '{0, 1'b1, 8'hF0, 8'h0F, 3'd1, 8'hE1, 0};
      vecs[3]  = '{1, 1'b1, 8'h0A, 8'h05, 3'd2, 8'h00, 0};
      vecs[4]  = '{0, 1'b0, 8'd100, 8'd50, 3'd0, 8'h96, 0};
      vecs[5]  = '{1, 1'b0, 8'd100, 8'd50, 3'd0, 8'h96, 0};
      vecs[6]  = '{1, 1'b0, 8'd100, 8'd50, 3'd1, 8'h32, 0};
      vecs[7]  = '{1, 1'b0, 8'd100, 8'd50, 3'd2, 8'h20, 0};
      vecs[8]  = '{1, 1'b0, 8'd100, 8'd50, 3'd3, 8'h76, 0};
      vecs[9]  = '{1, 1'b0, 8'd100, 8'd50, 3'd4, 8'h56, 0};
      vecs[10] = '{1, 1'b0, 8'd100, 8'd50, 3'd5, 8'h9B, 0};
      vecs[11] = '{1, 1'b0, 8'd100, 8'd50, 3'd6, 8'h46, 0};
      vecs[12] = '{1, 1'b0, 8'd100, 8'd50, 3'd7, 8'h65, 0};
      vecs[13] = '{0, 1'b0, 8'hA5, 8'h5A, 3'd4, 8'hFF, 5};
      vecs[14] = '{0, 1'b0, 8'h12, 8'h34, 3'd0, 8'h46, 0};

      wrap[0] = '{1, 1'b0, 8'h01, 8'h02, 3'd0, 8'h03, 0};
      wrap[1] = '{0, 1'b0, 8'hFF, 8'h01, 3'd0, 8'h00, 0};
      wrap[2] = '{1, 1'b0, 8'h80, 8'h01, 3'd1, 8'h7F, 0};
      wrap[3] = '{0, 1'b0, 8'h0F, 8'hF0, 3'd3, 8'hFF, 0};
      wrap[4] = '{1, 1'b0, 8'hAA, 8'h55, 3'd4, 8'hFF, 0};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a     = {8'h0A, 8'hF0};
      req_b     = {8'h05, 8'h0F};
      req_s     = {3'd2, 3'd1};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_r", {24'd0, rsp_r}, 32'd0);
      chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk_counters();
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i]);
      end

      // Abort in EXEC; last completed owner was requester 0, so ptr must fall back from 1 to 0.
      req_a[7:0] = 8'h11;
      req_b[7:0] = 8'h22;
      req_s[2:0] = 3'd0;
      req_valid  = 2'b01;
      rsp_ready  = 2'b11;
      #1;
      chk("abort_grant", {30'd0, req_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      req_valid = 2'b00;
      chk("abort_exec_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      exp_cnt = 0;
      chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rsp_r", {24'd0, rsp_r}, 32'd0);
      chk("abort_alu_a", {24'd0, alu_a}, 32'd0);
      chk("abort_alu_b", {24'd0, alu_b}, 32'd0);
      chk("abort_alu_s", {29'd0, alu_s}, 32'd0);
      chk_counters();
      rst_n     = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("abort_ptr_reset", {30'd0, req_ready}, 32'd1);
      req_valid = 2'b00;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_op(wrap[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
